// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: output-buffer state
// encoding and requester index constants.
package arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage : arb_pkg

// File: rtl/mux2_w.sv
// WIDTH-wide 2:1 data mux; sel=0 passes a, sel=1 passes b.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Pure combinational select, no other logic in the data path.
  always_comb begin
    y = sel ? b : a;
  end

endmodule : mux2_w

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter sharing one 2:1 mux into a one-entry
// registered output, with saturating per-source transfer counters.
//
// state | meaning
// ------+--------------------------------------------------
// EMPTY | output register holds no word, out_valid=0
// FULL  | output register holds a word awaiting out_ready
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic [WIDTH-1:0] mux_y;
  logic             grant;
  logic             winner;
  logic             can_load;
  logic             load;

  // Round-robin decision: a lone requester wins outright, a tie goes to the
  // source that did not win last; with nobody asking, sel parks on last_grant.
  always_comb begin
    grant  = req0_valid | req1_valid;
    winner = SRC0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant_q;
    end else if (req1_valid) begin
      winner = SRC1;
    end
    sel = grant ? winner : last_grant_q;
  end

  mux2_w #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a  (req0_data),
    .b  (req1_data),
    .sel(sel),
    .y  (mux_y)
  );

  // Next-state and handshake decode; reset suppresses any ready that cycle.
  always_comb begin
    state_d    = state_q;
    can_load   = !rst && ((state_q == EMPTY) || out_ready);
    load       = grant && can_load;
    req0_ready = load && (winner == SRC0) && req0_valid;
    req1_ready = load && (winner == SRC1) && req1_valid;
    case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        if (load)           state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output buffer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Output word, source tag, round-robin pointer and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_src_q    <= SRC0;
      last_grant_q <= SRC1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else if (load) begin
      out_data_q   <= mux_y;
      out_src_q    <= winner;
      last_grant_q <= winner;
      if (winner == SRC0) begin
        if (cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_ONE;
      end else begin
        if (cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + CNT_ONE;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed scenarios followed by random
// traffic, compared against a transaction-level model of the arbiter rules.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic             sel;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // Expected output words, {src, data}, in acceptance order.
  logic [WIDTH:0] exp_q[$];

  // Reference model: buffer occupancy, who won the last grant, transfer counts.
  bit m_full;
  bit m_last;
  int m_cnt0, m_cnt1;

  always #5 clk = ~clk;

  rr_mux_arbiter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .sel       (sel),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT shows a word, it must match the oldest
  // accepted-but-not-consumed word; it is retired when the consumer takes it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        chk("out_data", int'(out_data), int'(exp_q[0][WIDTH-1:0]));
        chk("out_src", int'(out_src), int'(exp_q[0][WIDTH]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle: check the handshake outputs against the model for the
  // inputs currently applied, then advance the model across the edge.
  task automatic step();
    bit any, win, acc;
    logic [WIDTH-1:0] d;
    @(negedge clk);
    any = req0_valid || req1_valid;
    if (req0_valid && req1_valid) win = !m_last;
    else                          win = req1_valid;
    acc = !rst && any && (!m_full || out_ready);
    d   = win ? req1_data : req0_data;
    chk("req0_ready", int'(req0_ready), int'(acc && !win));
    chk("req1_ready", int'(req1_ready), int'(acc && win));
    chk("sel", int'(sel), int'(any ? win : m_last));
    chk("out_valid", int'(out_valid), int'(m_full));
    chk("cnt0", int'(cnt0), m_cnt0);
    chk("cnt1", int'(cnt1), m_cnt1);
    @(posedge clk);
    if (rst) begin
      m_full = 0;
      m_last = 1;
      m_cnt0 = 0;
      m_cnt1 = 0;
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back({win, d});
      m_full = 1;
      m_last = win;
      if (win) m_cnt1 = (m_cnt1 < CNT_SAT) ? m_cnt1 + 1 : CNT_SAT;
      else     m_cnt0 = (m_cnt0 < CNT_SAT) ? m_cnt0 + 1 : CNT_SAT;
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic drive(input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1, input bit ordy);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] single_data[3];
    logic [WIDTH-1:0] held;
    single_data[0] = 8'h11;
    single_data[1] = 8'h22;
    single_data[2] = 8'h33;
    m_full = 0;
    m_last = 1;
    m_cnt0 = 0;
    m_cnt1 = 0;

    // Reset with both requesters asserting: nothing may be accepted.
    drive(1, 8'h5A, 1, 8'hA5, 1);
    rst = 1'b1;
    #1;
    do_reset(2);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_src", int'(out_src), 0);
    chk("reset_cnt0", int'(cnt0), 0);
    chk("reset_cnt1", int'(cnt1), 0);

    // Single source stream.
    for (int i = 0; i < 3; i++) begin
      drive(1, single_data[i], 0, 8'h00, 1);
      step();
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    step();
    chk("single_cnt0", int'(cnt0), 3);
    chk("single_cnt1", int'(cnt1), 0);

    // Contention from a fresh reset: requester 0 wins first, then alternation.
    do_reset(1);
    drive(1, 8'hA0, 1, 8'hB0, 1);
    repeat (6) step();

    // Backpressure with both valid: word and round-robin pointer frozen.
    out_ready = 1'b0;
    step();
    held = out_data;
    repeat (3) step();
    chk("bp_data_stable", int'(out_data), int'(held));
    out_ready = 1'b1;
    repeat (3) step();

    // Mid-stream reset while a word is buffered and requester 1 is valid.
    drive(0, 8'h00, 1, 8'hC3, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_cnt1", int'(cnt1), 0);
    drive(1, 8'h3C, 1, 8'hC3, 1);
    step();
    chk("midrst_first_src", int'(out_src), 0);
    drive(0, 8'h00, 0, 8'h00, 1);
    step();

    // Saturation: 20 words from requester 1 with a 4-bit counter.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 8'h00, 1, 8'(i + 1), 1);
      step();
    end
    chk("sat_cnt1", int'(cnt1), CNT_SAT);
    chk("sat_last_data", int'(out_data), 20);

    // Random traffic with random backpressure and occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            8'($urandom), ($urandom_range(0, 3) != 0));
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    // Drain and confirm nothing accepted was lost.
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (3) step();
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
